mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of one memory controller; grant takes one cycle, datapath is a pure mux.
// Backpressure: the owner sees ds_wait directly, the non-owner is held with wait=1 until the owner completes.
module mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [DATA_W-1:0] m0_data_tx,
   input  logic [DATA_W-1:0] m1_data_tx,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic              m1_read,
   input  logic              m1_write,
   output logic [DATA_W-1:0] m0_data_rx,
   output logic [DATA_W-1:0] m1_data_rx,
   output logic              m0_wait,
   output logic              m1_wait,
   output logic [ADDR_W-1:0] ds_address,
   output logic [DATA_W-1:0] ds_data_tx,
   output logic              ds_read,
   output logic              ds_write,
   input  logic [DATA_W-1:0] ds_data_rx,
   input  logic              ds_wait,
   output logic              busy,
   output logic              grant
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t state, state_nxt;
   logic   last_grant, last_grant_nxt;
   logic   m0_req, m1_req;

   assign m0_req = m0_read | m0_write;
   assign m1_req = m1_read | m1_write;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // An owner dropping its strobes early returns to IDLE without counting as a completion.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      case (state)
         IDLE: begin
            if (m0_req && m1_req)
               state_nxt = last_grant ? OWN0 : OWN1;
            else if (m0_req)
               state_nxt = OWN0;
            else if (m1_req)
               state_nxt = OWN1;
         end
         OWN0: begin
            if (!m0_req) begin
               state_nxt = IDLE;
            end else if (!ds_wait) begin
               state_nxt      = IDLE;
               last_grant_nxt = 1'b0;
            end
         end
         OWN1: begin
            if (!m1_req) begin
               state_nxt = IDLE;
            end else if (!ds_wait) begin
               state_nxt      = IDLE;
               last_grant_nxt = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Reset overrides the mux so nothing leaks downstream or back to a requester.
   always_comb begin
      ds_address = '0;
      ds_data_tx = '0;
      ds_read    = 1'b0;
      ds_write   = 1'b0;
      m0_wait    = 1'b1;
      m1_wait    = 1'b1;
      m0_data_rx = '0;
      m1_data_rx = '0;
      if (rst_n) begin
         case (state)
            OWN0: begin
               ds_address = m0_address;
               ds_data_tx = m0_data_tx;
               ds_read    = m0_read;
               ds_write   = m0_write;
               m0_wait    = ds_wait;
               m0_data_rx = ds_data_rx;
            end
            OWN1: begin
               ds_address = m1_address;
               ds_data_tx = m1_data_tx;
               ds_read    = m1_read;
               ds_write   = m1_write;
               m1_wait    = ds_wait;
               m1_data_rx = ds_data_rx;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy  = (state != IDLE);
      grant = last_grant;
      case (state)
         OWN0:    grant = 1'b0;
         OWN1:    grant = 1'b1;
         default: grant = last_grant;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions, a negedge monitor pops and checks them.
module tb_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic [15:0] m0_address, m1_address, ds_address;
   logic [7:0]  m0_data_tx, m1_data_tx, m0_data_rx, m1_data_rx, ds_data_tx, ds_data_rx;
   logic        m0_read, m0_write, m1_read, m1_write, m0_wait, m1_wait;
   logic        ds_read, ds_write, ds_wait, busy, grant;

   typedef struct {
      bit          m;
      bit          wr;
      logic [15:0] addr;
      logic [7:0]  wdat;
      logic [7:0]  rdat;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   lat = 1;
   int   cnt = 0;

   mem_arbiter #(.ADDR_W(16), .DATA_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_address(m0_address), .m1_address(m1_address),
      .m0_data_tx(m0_data_tx), .m1_data_tx(m1_data_tx),
      .m0_read(m0_read), .m0_write(m0_write), .m1_read(m1_read), .m1_write(m1_write),
      .m0_data_rx(m0_data_rx), .m1_data_rx(m1_data_rx),
      .m0_wait(m0_wait), .m1_wait(m1_wait),
      .ds_address(ds_address), .ds_data_tx(ds_data_tx), .ds_read(ds_read), .ds_write(ds_write),
      .ds_data_rx(ds_data_rx), .ds_wait(ds_wait),
      .busy(busy), .grant(grant)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic exp_t mk(input bit m, input bit wr, input logic [15:0] a,
                               input logic [7:0] wd, input logic [7:0] rd);
      exp_t e;
      e.m = m; e.wr = wr; e.addr = a; e.wdat = wd; e.rdat = rd;
      return e;
   endfunction

   // Downstream model: wait stays high for lat cycles of an active strobe; read data = addr[7:0] + 0x71.
   initial begin
      ds_wait    = 1'b1;
      ds_data_rx = 8'hEE;
      forever begin
         @(posedge clk);
         #2;
         if (ds_read || ds_write) begin
            cnt++;
            ds_wait    = (cnt <= lat);
            ds_data_rx = ds_wait ? 8'hEE : ds_address[7:0] + 8'h71;
         end else begin
            cnt        = 0;
            ds_wait    = 1'b1;
            ds_data_rx = 8'hEE;
         end
      end
   end

   task automatic check_done(input bit m);
      exp_t e;
      if (sb.size() == 0) begin
         chk($sformatf("unexpected_completion_m%0d", m), sb.size(), 1);
      end else begin
         e = sb.pop_front();
         chk("owner_order", m, e.m);
         chk("ds_address", ds_address, e.addr);
         chk("ds_strobes", {ds_read, ds_write}, {!e.wr, e.wr});
         if (e.wr) chk("ds_data_tx", ds_data_tx, e.wdat);
         else      chk("data_rx", m ? m1_data_rx : m0_data_rx, e.rdat);
      end
   endtask

   // Monitor: idle outputs must be quiet, and every completion must match the scoreboard head.
   initial begin
      forever begin
         @(negedge clk);
         if (!busy) begin
            chk("idle_ds", {ds_read, ds_write, ds_address, ds_data_tx}, 32'h0);
            chk("idle_rsp", {m0_wait, m1_wait, m0_data_rx, m1_data_rx}, {2'b11, 16'h0});
         end
         if ((m0_read || m0_write) && !m0_wait) check_done(1'b0);
         if ((m1_read || m1_write) && !m1_wait) check_done(1'b1);
      end
   end

   task automatic m_txn(input bit m, input bit wr, input logic [15:0] a, input logic [7:0] d);
      bit done = 1'b0;
      if (!m) begin
         m0_address = a; m0_data_tx = d; m0_read = !wr; m0_write = wr;
      end else begin
         m1_address = a; m1_data_tx = d; m1_read = !wr; m1_write = wr;
      end
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         if (m ? !m1_wait : !m0_wait) done = 1'b1;
      end
      chk($sformatf("txn_done_m%0d", m), done, 1);
      @(posedge clk);
      #1;
      if (!m) begin
         m0_address = '0; m0_data_tx = '0; m0_read = 1'b0; m0_write = 1'b0;
      end else begin
         m1_address = '0; m1_data_tx = '0; m1_read = 1'b0; m1_write = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      m0_address = '0; m1_address = '0; m0_data_tx = '0; m1_data_tx = '0;
      m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_grant", grant, 1);
      chk("rst_waits", {m0_wait, m1_wait}, 2'b11);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single read with three wait cycles
      lat = 3;
      sb.push_back(mk(0, 0, 16'h1234, 8'h00, 8'hA5));
      fork
         m_txn(0, 0, 16'h1234, 8'h00);
         begin
            @(negedge clk);
            chk("t1_no_strobe_first_cycle", {ds_read, busy}, 2'b00);
            @(negedge clk);
            chk("t1_ds_read", {ds_read, busy, grant}, 3'b110);
            chk("t1_ds_addr", ds_address, 16'h1234);
            chk("t1_m0_wait", m0_wait, 1);
            repeat (3) @(negedge clk);
            chk("t1_complete", {m0_wait, m0_data_rx}, {1'b0, 8'hA5});
            @(negedge clk);
            chk("t1_busy_fall", {busy, ds_read, grant}, 3'b000);
         end
      join
      @(posedge clk); #1;

      // Tie right after reset: m0 first, one idle cycle, then m1
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      lat = 1;
      sb.push_back(mk(0, 0, 16'h0040, 8'h00, 8'hB1));
      sb.push_back(mk(1, 0, 16'h2222, 8'h00, 8'h93));
      fork
         m_txn(0, 0, 16'h0040, 8'h00);
         m_txn(1, 0, 16'h2222, 8'h00);
         begin
            for (int i = 0; i < 40; i++) begin
               @(negedge clk);
               if (m0_read && !m0_wait) break;
            end
            @(negedge clk);
            chk("t2_gap", {ds_read, ds_write, busy}, 3'b000);
            @(negedge clk);
            chk("t2_m1_granted", {ds_read, busy, grant}, 3'b111);
         end
      join
      @(posedge clk); #1;

      // Round robin over four transactions
      sb.push_back(mk(0, 0, 16'h0101, 8'h00, 8'h72));
      sb.push_back(mk(1, 1, 16'h8001, 8'h5A, 8'h00));
      sb.push_back(mk(0, 0, 16'h0102, 8'h00, 8'h73));
      sb.push_back(mk(1, 0, 16'h8001, 8'h00, 8'h72));
      fork
         begin
            m_txn(0, 0, 16'h0101, 8'h00);
            m_txn(0, 0, 16'h0102, 8'h00);
         end
         begin
            m_txn(1, 1, 16'h8001, 8'h5A);
            m_txn(1, 0, 16'h8001, 8'h00);
         end
         begin
            for (int i = 0; i < 12; i++) begin
               @(negedge clk);
               if (ds_data_tx == 8'h5A || ds_address == 16'h8001)
                  chk("t3_m1_only_in_own1", {busy, grant}, 2'b11);
            end
         end
      join
      @(posedge clk); #1;

      // Non-preemption while m0 waits on downstream
      lat = 4;
      sb.push_back(mk(0, 0, 16'h0300, 8'h00, 8'h71));
      sb.push_back(mk(1, 0, 16'h0404, 8'h00, 8'h75));
      fork
         m_txn(0, 0, 16'h0300, 8'h00);
         begin
            @(posedge clk); #1;
            @(posedge clk); #1;
            m_txn(1, 0, 16'h0404, 8'h00);
         end
         begin
            repeat (3) @(negedge clk);
            chk("t4_m1_held", {m1_wait, m1_data_rx}, {1'b1, 8'h00});
            chk("t4_ds_addr_m0", ds_address, 16'h0300);
            @(negedge clk);
            chk("t4_owner_kept", {busy, grant, m1_wait}, 3'b101);
         end
      join
      @(posedge clk); #1;

      // Owner abort: no completion, last_grant untouched, next tie goes to m0
      lat = 20;
      m0_address = 16'h0500; m0_read = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      m0_read = 1'b0; m0_address = '0;
      @(negedge clk);
      chk("t5_abort_strobe", {busy, ds_read}, 2'b10);
      @(negedge clk);
      chk("t5_abort_idle", {busy, grant}, 2'b01);
      @(posedge clk); #1;
      lat = 1;
      sb.push_back(mk(0, 0, 16'h0600, 8'h00, 8'h71));
      sb.push_back(mk(1, 0, 16'h0601, 8'h00, 8'h72));
      fork
         m_txn(0, 0, 16'h0600, 8'h00);
         m_txn(1, 0, 16'h0601, 8'h00);
      join
      @(posedge clk); #1;

      // Reset during OWN1 after m0 was last owner
      sb.push_back(mk(0, 0, 16'h0900, 8'h00, 8'h71));
      m_txn(0, 0, 16'h0900, 8'h00);
      lat = 20;
      m1_address = 16'h0700; m1_data_tx = 8'h11; m1_write = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t6_own1", {busy, grant, ds_write}, 3'b111);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_rst_ds", {ds_read, ds_write}, 2'b00);
      chk("t6_rst_rsp", {m0_wait, m1_wait, m0_data_rx, m1_data_rx}, {2'b11, 16'h0});
      @(posedge clk); #1;
      m1_write = 1'b0; m1_address = '0; m1_data_tx = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t6_after_rst", {busy, grant}, 2'b01);
      @(posedge clk); #1;
      lat = 1;
      sb.push_back(mk(0, 0, 16'h0800, 8'h00, 8'h71));
      sb.push_back(mk(1, 0, 16'h0801, 8'h00, 8'h72));
      fork
         m_txn(0, 0, 16'h0800, 8'h00);
         m_txn(1, 0, 16'h0801, 8'h00);
      join
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
